// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program counter.
package pc_pkg;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] addr_t;

   localparam addr_t       DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam int unsigned DEFAULT_INSTR_BYTES  = 4;

   // Sequential fetch address; wraps modulo 2^XLEN.
   function automatic addr_t next_seq_pc(input addr_t cur, input int unsigned bytes);
      return cur + addr_t'(bytes);
   endfunction

endpackage

// File: rtl/program_counter_if.sv
// Fetch control bundle: stall/redirect in, fetch address out.
// PC_ALIGN_CHECK_EN adds the misaligned-redirect flag.
interface program_counter_if;
   import pc_pkg::*;

   logic  stall;
   logic  redirect_valid;
   addr_t redirect_pc;
   addr_t pc;
`ifdef PC_ALIGN_CHECK_EN
   logic  misaligned;

   modport master (output stall, output redirect_valid, output redirect_pc,
                   input pc, input misaligned);
   modport slave  (input stall, input redirect_valid, input redirect_pc,
                   output pc, output misaligned);
`else
   modport master (output stall, output redirect_valid, output redirect_pc,
                   input pc);
   modport slave  (input stall, input redirect_valid, input redirect_pc,
                   output pc);
`endif

endinterface

// File: rtl/program_counter.sv
// Fetch-stage PC register: redirect > stall > sequential increment.
// PC_ALIGN_CHECK_EN masks unaligned redirect targets and flags them.
module program_counter
   import pc_pkg::*;
#(
   parameter addr_t       RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int unsigned INSTR_BYTES  = DEFAULT_INSTR_BYTES
) (
   input logic              clk,
   input logic              rst,
   program_counter_if.slave bus
);

   addr_t pc_q, pc_d;

`ifdef PC_ALIGN_CHECK_EN
   localparam addr_t LOW_MASK = addr_t'(INSTR_BYTES - 1);
   logic mis_q, mis_d;
`endif

   // An X on stall/redirect_valid falls through both ifs, i.e. treated as 0.
   always_comb begin
      pc_d = next_seq_pc(pc_q, INSTR_BYTES);
`ifdef PC_ALIGN_CHECK_EN
      mis_d = 1'b0;
`endif
      if (bus.redirect_valid == 1'b1) begin
`ifdef PC_ALIGN_CHECK_EN
         pc_d  = bus.redirect_pc & ~LOW_MASK;
         mis_d = |(bus.redirect_pc & LOW_MASK);
`else
         pc_d  = bus.redirect_pc;
`endif
      end else if (bus.stall == 1'b1) begin
         pc_d = pc_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q  <= RESET_VECTOR;
`ifdef PC_ALIGN_CHECK_EN
         mis_q <= 1'b0;
`endif
      end else begin
         pc_q  <= pc_d;
`ifdef PC_ALIGN_CHECK_EN
         mis_q <= mis_d;
`endif
      end
   end

   assign bus.pc = pc_q;
`ifdef PC_ALIGN_CHECK_EN
   assign bus.misaligned = mis_q;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter (RESET_VECTOR=0, INSTR_BYTES=4).
module tb_program_counter;
   import pc_pkg::*;

   logic clk;
   logic rst;
   program_counter_if bus ();

   program_counter #(.RESET_VECTOR(32'h0), .INSTR_BYTES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        stall;
      logic        rv;
      logic [31:0] rpc;
      logic [31:0] pc;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic        mis;
   } exp_t;

   localparam int NV = 23;
   vec_t vecs [NV];
   exp_t sb [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive at the falling edge, queue the expectation, compare 1 ns after the next rising edge.
   task automatic apply(input string name, input logic st, input logic rv,
                        input logic [31:0] rpc, input logic [31:0] exp_pc, input logic exp_mis);
      exp_t e;
      bus.stall          = st;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      e.pc  = exp_pc;
      e.mis = exp_mis;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({name, ".pc"}, bus.pc, e.pc);
`ifdef PC_ALIGN_CHECK_EN
      check({name, ".misaligned"}, {31'b0, bus.misaligned}, {31'b0, e.mis});
`endif
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs = '{
         '{1'b0, 1'b0, 32'h0,         32'h0000_0004},
         '{1'b0, 1'b0, 32'h0,         32'h0000_0008},
         '{1'b0, 1'b0, 32'h0,         32'h0000_000C},
         '{1'b0, 1'b0, 32'h0,         32'h0000_0010},
         '{1'b1, 1'b0, 32'h0,         32'h0000_0010},
         '{1'b1, 1'b0, 32'h0,         32'h0000_0010},
         '{1'b0, 1'b0, 32'h0,         32'h0000_0014},
         '{1'b0, 1'b1, 32'h100,       32'h0000_0100},
         '{1'b0, 1'b0, 32'h0,         32'h0000_0104},
         '{1'b0, 1'b0, 32'h0,         32'h0000_0108},
         '{1'b0, 1'b0, 32'h0,         32'h0000_010C},
         '{1'b0, 1'b0, 32'h0,         32'h0000_0110},
         '{1'b1, 1'b1, 32'h200,       32'h0000_0200},
         '{1'b1, 1'b0, 32'h0,         32'h0000_0200},
         '{1'b1, 1'b0, 32'h0,         32'h0000_0200},
         '{1'b0, 1'b0, 32'h0,         32'h0000_0204},
         '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC},
         '{1'b0, 1'b0, 32'h0,         32'h0000_0000},
         '{1'b0, 1'b0, 32'h0,         32'h0000_0004},
         '{1'b0, 1'b1, 32'h300,       32'h0000_0300},
         '{1'b0, 1'b1, 32'h300,       32'h0000_0300},
         '{1'b0, 1'b1, 32'h400,       32'h0000_0400},
         '{1'b0, 1'b0, 32'h0,         32'h0000_0404}
      };

      rst                = 1'b1;
      bus.stall          = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      #2;
      check("reset_immediate", bus.pc, 32'h0);
      @(posedge clk); #1;
      check("reset_hold", bus.pc, 32'h0);
      @(negedge clk);   // 10 ns
      @(negedge clk);   // 20 ns
      rst = 1'b0;

      for (int i = 0; i < NV; i++)
         apply($sformatf("vec%0d", i), vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].pc, 1'b0);

`ifdef PC_ALIGN_CHECK_EN
      apply("misalign_redirect", 1'b0, 1'b1, 32'h102, 32'h100, 1'b1);
      apply("misalign_clear",    1'b0, 1'b0, 32'h0,   32'h104, 1'b0);
      apply("align_redirect",    1'b0, 1'b1, 32'h208, 32'h208, 1'b0);
`else
      apply("raw_redirect",      1'b0, 1'b1, 32'h102, 32'h102, 1'b0);
      apply("raw_increment",     1'b0, 1'b0, 32'h0,   32'h106, 1'b0);
`endif

      // Async reset between edges while a redirect is being offered.
      #2;
      rst                = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h500;
      #1;
      check("midrun_reset_async", bus.pc, 32'h0);
      @(posedge clk); #1;
      check("midrun_reset_drop_redirect", bus.pc, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
      check("midrun_reset_misaligned", {31'b0, bus.misaligned}, 32'h0);
`endif
      @(negedge clk);
      rst                = 1'b0;
      bus.redirect_valid = 1'b0;
      apply("post_reset_first", 1'b0, 1'b0, 32'h0, 32'h4, 1'b0);
      apply("post_reset_second", 1'b0, 1'b0, 32'h0, 32'h8, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
